fetch_align: RTL

- Instruction fetch and alignment stage sitting directly upstream of the decoder.
- Issues word-aligned reads to instruction memory and tracks the halfword-granular PC.
- Buffers a leftover upper halfword so RV32C compressed instructions, and 32-bit instructions straddling a word boundary, reach decode as one right-justified 32-bit item with its PC.
- Handles control-flow redirects, including to halfword-aligned targets.

---
 rtl/fetch_align_if.sv | 24 ++
 rtl/fetch_align.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fetch_align_if.sv
// Fetch-to-memory and fetch-to-decode signal bundle for the fetch/align stage.
// The master side is the aligner; the slave side is memory plus decode.
interface fetch_align_if;
  logic        O_memreq;
  logic [31:0] O_memaddr;
  logic [31:0] I_memdata;
  logic        I_memvalid;
  logic        O_valid;
  logic [31:0] O_instr;
  logic [31:0] O_pc;
  logic        I_ready;
  logic        I_redirect;
  logic [31:0] I_target;

  modport master (
    output O_memreq, O_memaddr, O_valid, O_instr, O_pc,
    input  I_memdata, I_memvalid, I_ready, I_redirect, I_target
  );

  modport slave (
    input  O_memreq, O_memaddr, O_valid, O_instr, O_pc,
    output I_memdata, I_memvalid, I_ready, I_redirect, I_target
  );
endinterface

// File: rtl/fetch_align.sv
// Instruction fetch and halfword alignment: word reads from memory, one
// right-justified 32-bit item (plain or RV32C) per decode transfer.
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           I_clk,
  input logic           I_rst,
  fetch_align_if.master bus
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_OUT, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] hbuf_q, hbuf_d;
  logic        hvalid_q, hvalid_d;
  logic        memreq_q, memreq_d;
  logic [31:0] memaddr_q, memaddr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC & ~32'd1;
      hbuf_q    <= 16'h0000;
      hvalid_q  <= 1'b0;
      memreq_q  <= 1'b0;
      memaddr_q <= 32'h0;
      valid_q   <= 1'b0;
      instr_q   <= 32'h0;
      opc_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hbuf_q    <= hbuf_d;
      hvalid_q  <= hvalid_d;
      memreq_q  <= memreq_d;
      memaddr_q <= memaddr_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      opc_q     <= opc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hbuf_d    = hbuf_q;
    hvalid_d  = hvalid_q;
    memreq_d  = 1'b0;
    memaddr_d = memaddr_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    opc_d     = opc_q;

    case (state_q)
      S_FETCH: begin
        if (hvalid_q && (hbuf_q[1:0] != 2'b11)) begin
          instr_d  = {16'h0000, hbuf_q};
          opc_d    = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + 32'd2;
          hvalid_d = 1'b0;
          state_d  = S_OUT;
        end else begin
          // A buffered 32-bit head needs the following word for its upper half.
          memreq_d  = 1'b1;
          memaddr_d = (pc_q + (hvalid_q ? 32'd2 : 32'd0)) & ~32'd3;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.I_memvalid) begin
          if (hvalid_q) begin
            instr_d = {bus.I_memdata[15:0], hbuf_q};
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            hbuf_d  = bus.I_memdata[31:16];
            state_d = S_OUT;
          end else if (pc_q[1]) begin
            hbuf_d   = bus.I_memdata[31:16];
            hvalid_d = 1'b1;
            state_d  = S_FETCH;
          end else if (bus.I_memdata[1:0] == 2'b11) begin
            instr_d = bus.I_memdata;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = S_OUT;
          end else begin
            instr_d  = {16'h0000, bus.I_memdata[15:0]};
            opc_d    = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd2;
            hbuf_d   = bus.I_memdata[31:16];
            hvalid_d = 1'b1;
            state_d  = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (bus.I_ready) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (bus.I_memvalid) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Redirect wins over everything; an unanswered request must still be drained.
    if (bus.I_redirect) begin
      valid_d  = 1'b0;
      hvalid_d = 1'b0;
      memreq_d = 1'b0;
      pc_d     = bus.I_target & ~32'd1;
      if (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !bus.I_memvalid) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  assign bus.O_memreq  = memreq_q;
  assign bus.O_memaddr = memaddr_q;
  assign bus.O_valid   = valid_q;
  assign bus.O_instr   = instr_q;
  assign bus.O_pc      = opc_q;

endmodule
